// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one rotate unit.
// Round-robin grant in IDLE, registered rotate in EXEC, result held in DONE
// until the consumer takes it.
module shift_arbiter #(
  parameter int         WIDTH   = 32,
  parameter int         SHW     = 5,
  parameter logic [4:0] FS_ROTL = 5'h1A,
  parameter logic [4:0] FS_ROTR = 5'h1B
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [4:0]       req_fs0,
  input  logic [SHW-1:0]   req_shamt0,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [4:0]       req_fs1,
  input  logic [SHW-1:0]   req_shamt1,
  input  logic [WIDTH-1:0] req_data1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;        // port favoured when both request
  logic [4:0]       fs_q, fs_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;

  logic             gnt;                 // winning port index in IDLE
  logic [2*WIDTH-1:0] dbl_l, dbl_r;
  logic [WIDTH-1:0] rot_y;

  // Winner selection: a lone requester wins; on contention the pointer decides.
  always_comb begin
    gnt = 1'b0;
    if (req_valid == 2'b11) gnt = ptr_q;
    else                    gnt = req_valid[1];
  end

  // Rotate via a doubled operand so k=0 needs no special case.
  always_comb begin
    dbl_l = {data_q, data_q} << shamt_q;
    dbl_r = {data_q, data_q} >> shamt_q;
    rot_y = '0;
    if (fs_q == FS_ROTL)      rot_y = dbl_l[2*WIDTH-1:WIDTH];
    else if (fs_q == FS_ROTR) rot_y = dbl_r[WIDTH-1:0];
  end

  // Next-state, latch and handshake logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    fs_d       = fs_q;
    shamt_d    = shamt_q;
    data_d     = data_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    req_ready  = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          fs_d      = gnt ? req_fs1    : req_fs0;
          shamt_d   = gnt ? req_shamt1 : req_shamt0;
          data_d    = gnt ? req_data1  : req_data0;
          id_d      = gnt;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = rot_y;
        rsp_id_d   = id_q;
        state_d    = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          // Favour the other port next time so dual requests alternate.
          ptr_d   = ~rsp_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      fs_q       <= '0;
      shamt_q    <= '0;
      data_q     <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      fs_q       <= fs_d;
      shamt_q    <= shamt_d;
      data_q     <= data_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule
